// File: rtl/decoder_stream.sv
// Registered binary-to-one-hot/thermometer decoder with valid/ready stream and two-entry skid buffer.
// Optional thermometer mode compiled in by defining DECODER_STREAM_THERMO_EN.
module decoder_stream #(
   parameter int unsigned IN_W  = 3,
   parameter int unsigned OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   input  logic             in_thermo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic [OUT_W-1:0] r_or_data;
   logic             r_or_err;
   logic [OUT_W-1:0] r_sr_data;
   logic             r_sr_err;
   logic [7:0]       r_err_cnt;

   logic             w_thermo;
   logic [OUT_W-1:0] w_dec;
   logic             w_err;
   logic             w_acc;
   logic             w_drain;
   logic             w_or_load_new;
   logic             w_or_load_sr;
   logic             w_sr_load;

`ifdef DECODER_STREAM_THERMO_EN
   assign w_thermo = in_thermo;
`else
   logic w_unused_thermo;
   assign w_unused_thermo = in_thermo;
   assign w_thermo        = 1'b0;
`endif

   // Decode on the input side; only the vector and error flag are buffered.
   always_comb begin
      int unsigned w_code;
      w_code = 32'(in_code);
      w_err  = (w_code >= OUT_W);
      w_dec  = '0;
      for (int unsigned i = 0; i < OUT_W; i++) begin
         w_dec[i] = w_thermo ? (i <= w_code) : (i == w_code);
      end
      if (w_err) begin
         w_dec = '0;
      end
   end

   assign w_acc   = in_valid && r_in_ready;
   assign w_drain = (r_state != EMPTY) && out_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_or_load_new = 1'b0;
      w_or_load_sr  = 1'b0;
      w_sr_load     = 1'b0;
      unique case (r_state)
         EMPTY: begin
            if (w_acc) begin
               w_state_nxt   = ONE;
               w_or_load_new = 1'b1;
            end
         end
         ONE: begin
            if (w_acc && !w_drain) begin
               w_state_nxt = TWO;
               w_sr_load   = 1'b1;
            end else if (!w_acc && w_drain) begin
               w_state_nxt = EMPTY;
            end else if (w_acc && w_drain) begin
               w_or_load_new = 1'b1;
            end
         end
         TWO: begin
            if (w_drain) begin
               w_state_nxt  = ONE;
               w_or_load_sr = 1'b1;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
         r_or_data  <= '0;
         r_or_err   <= 1'b0;
         r_sr_data  <= '0;
         r_sr_err   <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         // Registered ready: derived from next state, so no path from out_ready.
         r_in_ready <= (w_state_nxt != TWO);
         if (w_or_load_new) begin
            r_or_data <= w_dec;
            r_or_err  <= w_err;
         end else if (w_or_load_sr) begin
            r_or_data <= r_sr_data;
            r_or_err  <= r_sr_err;
         end
         if (w_sr_load) begin
            r_sr_data <= w_dec;
            r_sr_err  <= w_err;
         end
         if (w_acc && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != EMPTY);
   assign out_data  = r_or_data;
   assign out_err   = r_or_err;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_decoder_stream.sv
// Directed self-checking bench for decoder_stream: an 8-output and a 6-output instance share stimulus.
module tb_decoder_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_code;
   logic       in_thermo;
   logic       out_ready;

   logic       a_in_ready, a_out_valid, a_out_err;
   logic [7:0] a_out_data, a_err_cnt;
   logic       b_in_ready, b_out_valid, b_out_err;
   logic [5:0] b_out_data;
   logic [7:0] b_err_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   decoder_stream #(.IN_W(3), .OUT_W(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_code(in_code), .in_thermo(in_thermo),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_err(a_out_err), .err_cnt(a_err_cnt)
   );

   decoder_stream #(.IN_W(3), .OUT_W(6)) u_dut6 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_code(in_code), .in_thermo(in_thermo),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_err(b_out_err), .err_cnt(b_err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs and samples move 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] exp_th;
   logic [7:0] exp_cnt;

   initial begin
      in_code   = '0;
      in_thermo = 1'b0;
      out_ready = 1'b1;
      do_reset();

      check("rst_out_valid", a_out_valid, 0);
      check("rst_in_ready",  a_in_ready,  1);
      check("rst_out_data",  a_out_data,  0);
      check("rst_out_err",   a_out_err,   0);
      check("rst_err_cnt",   a_err_cnt,   0);

      // Basic one-hot decode, back-to-back
      in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_code = 3'(c);
         tick();
         check("basic_valid", a_out_valid, 1);
         check("basic_data",  a_out_data,  32'(8'h01 << c));
         check("basic_err",   a_out_err,   0);
         check("basic_ready", a_in_ready,  1);
         check("basic6_err",  b_out_err,   (c >= 6) ? 1 : 0);
      end
      in_valid = 1'b0;
      tick();
      check("basic_drained", a_out_valid, 0);

      // Out of range on the 6-output instance
      do_reset();
      in_valid = 1'b1;
      in_code  = 3'd6;
      tick();
      check("oor6_data", b_out_data, 0);
      check("oor6_err",  b_out_err,  1);
      in_code = 3'd7;
      tick();
      check("oor7_data", b_out_data, 0);
      check("oor7_err",  b_out_err,  1);
      check("oor7_data8", a_out_data, 8'h80);
      in_valid = 1'b0;
      tick();
      check("oor_cnt6", b_err_cnt, 2);
      check("oor_cnt8", a_err_cnt, 0);

      // Backpressure
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 3'd1;
      tick();
      check("bp1_valid", a_out_valid, 1);
      check("bp1_data",  a_out_data,  8'h02);
      check("bp1_ready", a_in_ready,  1);
      in_code = 3'd2;
      tick();
      check("bp2_ready", a_in_ready, 0);
      check("bp2_data",  a_out_data, 8'h02);
      in_code = 3'd3;
      tick();
      check("bp3_ready", a_in_ready, 0);
      check("bp3_hold",  a_out_data, 8'h02);
      out_ready = 1'b1;
      tick();
      check("bp_drain1_data",  a_out_data, 8'h04);
      check("bp_drain1_ready", a_in_ready, 1);
      tick();
      check("bp_drain2_data",  a_out_data,  8'h08);
      check("bp_drain2_valid", a_out_valid, 1);
      in_valid = 1'b0;
      tick();
      check("bp_empty", a_out_valid, 0);

      // Thermometer vs one-hot
      do_reset();
`ifdef DECODER_STREAM_THERMO_EN
      exp_th = 8'h0F;
`else
      exp_th = 8'h08;
`endif
      in_valid  = 1'b1;
      in_code   = 3'd3;
      in_thermo = 1'b1;
      tick();
      check("thermo_on",  a_out_data, exp_th);
      in_thermo = 1'b0;
      tick();
      check("thermo_off", a_out_data, 8'h08);
      in_valid = 1'b0;
      tick();

      // Saturation of the error counter
      do_reset();
      in_valid = 1'b1;
      in_code  = 3'd7;
      for (int i = 0; i < 300; i++) begin
         tick();
         exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
         check("sat_valid", b_out_valid, 1);
         check("sat_err",   b_out_err,   1);
         check("sat_cnt",   b_err_cnt,   exp_cnt);
      end
      in_valid = 1'b0;
      tick();
      check("sat_hold", b_err_cnt, 255);

      // Reset while in TWO
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 3'd6;
      tick();
      in_code = 3'd7;
      tick();
      check("mid_two_ready", b_in_ready, 0);
      check("mid_cnt_pre",   b_err_cnt,  2);
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_valid", b_out_valid, 0);
      check("mid_ready", b_in_ready,  1);
      check("mid_cnt",   b_err_cnt,   0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_no_stale", b_out_valid, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/decoder_stream.md
# decoder_stream

Parametrised, registered binary-to-one-hot decoder with a valid/ready stream interface and a two-entry skid buffer. Generalises the fixed 3-to-8 combinational decoder to arbitrary code width and output width, adds out-of-range detection, a saturating error counter, and an optional thermometer mode. It sits between a code-producing master (arbiter grant index, address field) and a consumer that may apply backpressure.

## Interface
- `IN_W`, 3: code width in bits; legal range 1..8.
- `OUT_W`, 8: output width; legal range 1..2**IN_W. Codes >= OUT_W are out of range.
- `clk`  input  1  clock; all logic is rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  input code is valid.
- `in_ready`  output  1  block can accept a code this cycle.
- `in_code`  input  IN_W  binary code.
- `in_thermo`  input  1  per-beat mode select: 0 = one-hot, 1 = thermometer. Ignored when the thermometer feature is compiled out.
- `out_valid`  output  1  output beat is valid.
- `out_ready`  input  1  consumer accepts the output beat.
- `out_data`  output  OUT_W  decoded vector.
- `out_err`  output  1  the beat's code was out of range.
- `err_cnt`  output  8  saturating count of accepted out-of-range codes.

## Operation
- The input handshake completes when `in_valid && in_ready`. The output handshake completes when `out_valid && out_ready`.
- Decode for code c:
  - One-hot: bit c is set when c < OUT_W. Otherwise `out_data`=0 and `out_err`=1.
  - Thermometer: bits [c:0] are set when c < OUT_W. Otherwise `out_data`=0 and `out_err`=1.
- Decode is computed on the input side. The decoded vector and error flag are stored, never the raw code.
- Storage is an output register (OR) plus a skid register (SR). State machine:
  - EMPTY: OR and SR are empty.
    - Accept → ONE.
  - ONE: OR is full, SR is empty.
    - Accept without drain → TWO.
    - Drain without accept → EMPTY.
    - Accept with drain: OR takes the new beat; state stays ONE.
  - TWO: OR and SR are full.
    - Drain moves SR into OR → ONE.
    - No accept is possible in TWO.
- `in_ready` is registered and equals (state != TWO). It has no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY). `out_data` and `out_err` come from OR.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- `err_cnt` increments by 1 on every accepted beat whose decode sets the error flag. The increment happens at acceptance, not at output. The counter saturates at 255 and does not wrap.
- Output values are held stable while `out_valid && !out_ready`.

## Timing
- Reset values: state = EMPTY, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_err`=0, `err_cnt`=0. SR contents are cleared to 0.
- Reset mid-operation discards all buffered beats. The first cycle after `rst` is deasserted behaves as EMPTY.
- Latency: a code accepted at edge N appears on `out_data` after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: with `out_ready` held 0, two beats are accepted, then `in_ready` drops in the following cycle.
- Simultaneous accept and drain in ONE: the occupancy is unchanged and OR is replaced with the new beat.
- In TWO, a drain makes `in_ready`=1 in the next cycle, not the same one.
- An error beat at `err_cnt`=255: the beat is still passed through with `out_err`=1, and the count stays at 255.

## Configuration
- `DECODER_STREAM_THERMO_EN`:
  - Defined: the thermometer mode is compiled in, and `in_thermo` selects the mode per beat.
  - Undefined: only one-hot decode exists, `in_thermo` is left unconnected internally, and the result is identical to `in_thermo`=0.
- The port list is the same in both builds.

## Test plan
- Reset and basic decode (IN_W=3, OUT_W=8, `out_ready`=1): send codes 0..7 back-to-back. Expect `out_data` = 0x01, 0x02 … 0x80 on consecutive cycles, each one cycle after acceptance, with `out_err`=0 throughout.
- Out of range (IN_W=3, OUT_W=6): send codes 6 and 7. Expect `out_data`=0, `out_err`=1 for both, and `err_cnt`=2.
- Backpressure: with `out_ready`=0, send codes 1, 2, 3. Expect 1 and 2 accepted and `in_ready`=0 from the next cycle. Then raise `out_ready`. Expect outputs 0x02, 0x04, 0x08 in order with code 3 accepted after the first drain.
- Thermometer (macro defined): send code 3 with `in_thermo`=1, then code 3 with `in_thermo`=0. Expect 0x0F, then 0x08. With the macro undefined, expect 0x08 for both.
- Saturation: send 300 out-of-range codes. Expect `err_cnt` = 255 and held, with every beat still delivered with `out_err`=1.
- Reset mid-operation: in state TWO, pulse `rst` for one cycle. Expect `out_valid`=0, `in_ready`=1, and `err_cnt`=0 on the next cycle, with no stale beats emitted afterwards.
